// File: rtl/vlsu_pkg.sv
// Shared types and address helpers for the strided vector load/store unit.
package vlsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR,
    DONE
  } vlsu_state_e;

  // Row number of a byte address: drop the byte-within-row bits.
  function automatic logic [63:0] row_index(input logic [63:0] addr, input int row_lg);
    return addr >> row_lg;
  endfunction

  // Lane number inside the row: byte-within-row offset divided by the element size.
  function automatic logic [63:0] lane_index(input logic [63:0] addr, input int row_lg,
                                             input int eb_lg);
    return (addr & ((64'd1 << row_lg) - 64'd1)) >> eb_lg;
  endfunction

  // An element is misaligned when its address is not a multiple of the element size.
  function automatic logic misaligned(input logic [63:0] addr, input int eb_lg);
    return (addr & ((64'd1 << eb_lg) - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/vlsu_lane_sel.sv
// Combinational lane helpers: pick a lane out of a row, drop a lane into a row,
// and build the byte-enable mask that covers one lane.
module vlsu_lane_sel #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  localparam int ROW_W = LANES * LANE_W,
  localparam int ROW_B = ROW_W / 8,
  localparam int EB    = LANE_W / 8,
  localparam int IW    = $clog2(LANES)
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [IW-1:0]     ext_idx,
  output logic [LANE_W-1:0] ext_data,
  input  logic [ROW_W-1:0]  ins_row,
  input  logic [IW-1:0]     ins_idx,
  input  logic [LANE_W-1:0] ins_data,
  output logic [ROW_W-1:0]  ins_out,
  input  logic [IW-1:0]     mask_idx,
  output logic [ROW_B-1:0]  mask
);

  // Extract the addressed lane from a full row.
  always_comb begin
    ext_data = row[ext_idx*LANE_W +: LANE_W];
  end

  // Replace one lane of a row, leaving the others untouched.
  always_comb begin
    ins_out = ins_row;
    ins_out[ins_idx*LANE_W +: LANE_W] = ins_data;
  end

  // Enable exactly the EB bytes that belong to the selected lane.
  always_comb begin
    mask = '0;
    mask[mask_idx*EB +: EB] = '1;
  end

endmodule

// File: rtl/vector_lsu_strided.sv
// Vector load/store unit with unit-stride fast path, strided gather/scatter and
// per-element misalignment reporting, in front of a wide single-port RAM.
module vector_lsu_strided #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int RAM_AW = 14,
  parameter int ADDR_W = 32,
  localparam int ROW_W = LANES * LANE_W,
  localparam int ROW_B = ROW_W / 8,
  localparam int EB    = LANE_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_vector,
  input  logic              req_stride_en,
  input  logic [ADDR_W-1:0] req_stride,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LANE_W-1:0] req_sdata,
  input  logic [ROW_W-1:0]  req_vdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [LANE_W-1:0] resp_sdata,
  output logic [ROW_W-1:0]  resp_vdata,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [ROW_B-1:0]  ram_byteena,
  output logic [ROW_W-1:0]  ram_wdata,
  output logic              ram_wren,
  input  logic [ROW_W-1:0]  ram_rdata
);
  import vlsu_pkg::*;

  localparam int IW     = $clog2(LANES);
  localparam int ROW_LG = $clog2(ROW_B);
  localparam int EB_LG  = $clog2(EB);

  vlsu_state_e       state;
  logic [IW-1:0]     cnt;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] step;
  logic              fast_q;
  logic              vector_q;
  logic              err_q;
  logic [ROW_W-1:0]  vdata_q;
  logic [ROW_W-1:0]  vacc;

  logic [ADDR_W-1:0] issue_addr;
  logic [RAM_AW-1:0] issue_row;
  logic [IW-1:0]     issue_lane;
  logic [IW-1:0]     cur_lane;
  logic [IW-1:0]     cnt_nxt;
  logic              issue_mis;
  logic              cur_mis;
  logic              acc_fast;
  logic              last_elem;
  logic [ADDR_W-1:0] acc_step;
  logic [LANE_W-1:0] st_elem;
  logic [LANE_W-1:0] ext_data;
  logic [LANE_W-1:0] cap_val;
  logic [ROW_W-1:0]  ins_out;
  logic [ROW_W-1:0]  vacc_next;
  logic [ROW_W-1:0]  wr_row;
  logic [ROW_B-1:0]  lane_mask;
  logic [ROW_B-1:0]  wr_be;

  assign busy = !req_ready;

  // The address about to be driven: the request base when idle, else the next element.
  assign issue_addr = (state == IDLE) ? req_addr : cur + step;
  assign issue_row  = RAM_AW'(row_index(64'(issue_addr), ROW_LG));
  assign issue_lane = IW'(lane_index(64'(issue_addr), ROW_LG, EB_LG));
  assign issue_mis  = misaligned(64'(issue_addr), EB_LG);
  assign cur_lane   = IW'(lane_index(64'(cur), ROW_LG, EB_LG));
  assign cur_mis    = misaligned(64'(cur), EB_LG);
  assign cnt_nxt    = cnt + IW'(1);
  assign last_elem  = (cnt == IW'(LANES - 1));

  // Scalars and row-aligned unit-stride vectors touch a single row; the rest go element by element.
  assign acc_fast = !req_vector || (!req_stride_en && (req_addr[ROW_LG-1:0] == '0));
  assign acc_step = (req_vector && req_stride_en) ? req_stride : ADDR_W'(EB);

  assign st_elem   = (state == IDLE) ? req_vdata[LANE_W-1:0] : vdata_q[cnt_nxt*LANE_W +: LANE_W];
  assign cap_val   = cur_mis ? '0 : ext_data;
  assign vacc_next = fast_q ? ram_rdata : ins_out;

  assign wr_row = (state == IDLE && !req_vector) ? {LANES{req_sdata}} :
                  (state == IDLE && acc_fast)    ? req_vdata : {LANES{st_elem}};
  assign wr_be  = (state == IDLE && req_vector && acc_fast) ? '1 :
                  issue_mis ? '0 : lane_mask;

  vlsu_lane_sel #(
    .LANES (LANES),
    .LANE_W(LANE_W)
  ) u_lane_sel (
    .row     (ram_rdata),
    .ext_idx (cur_lane),
    .ext_data(ext_data),
    .ins_row (vacc),
    .ins_idx (cnt),
    .ins_data(cap_val),
    .ins_out (ins_out),
    .mask_idx(issue_lane),
    .mask    (lane_mask)
  );

  // Request FSM with registered RAM strobes, element walker and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cur         <= '0;
      step        <= '0;
      fast_q      <= 1'b0;
      vector_q    <= 1'b0;
      err_q       <= 1'b0;
      vdata_q     <= '0;
      vacc        <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_sdata  <= '0;
      resp_vdata  <= '0;
      ram_addr    <= '0;
      ram_byteena <= '0;
      ram_wdata   <= '0;
      ram_wren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            cur       <= req_addr;
            step      <= acc_step;
            fast_q    <= acc_fast;
            vector_q  <= req_vector;
            vdata_q   <= req_vdata;
            err_q     <= req_write && issue_mis;
            ram_addr  <= issue_row;
            if (req_write) begin
              state       <= WR;
              ram_wren    <= 1'b1;
              ram_byteena <= wr_be;
              ram_wdata   <= wr_row;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          state <= RD_CAPT;
        end
        RD_CAPT: begin
          vacc <= vacc_next;
          if (fast_q || last_elem) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= err_q || cur_mis;
            if (vector_q) resp_vdata <= vacc_next;
            else          resp_sdata <= cap_val;
          end else begin
            state    <= RD_ISSUE;
            cnt      <= cnt_nxt;
            cur      <= issue_addr;
            ram_addr <= issue_row;
            err_q    <= err_q || cur_mis;
          end
        end
        WR: begin
          if (fast_q || last_elem) begin
            state       <= DONE;
            ram_wren    <= 1'b0;
            ram_byteena <= '0;
            resp_valid  <= 1'b1;
            resp_err    <= err_q;
          end else begin
            cnt         <= cnt_nxt;
            cur         <= issue_addr;
            ram_addr    <= issue_row;
            ram_byteena <= wr_be;
            ram_wdata   <= wr_row;
            err_q       <= err_q || issue_mis;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu_strided.sv
// Self-checking bench for vector_lsu_strided: directed scenarios plus random
// traffic against a byte-addressed memory model.
module tb_vector_lsu_strided;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int RAM_AW = 14;
  localparam int ADDR_W = 32;
  localparam int ROW_W  = LANES * LANE_W;
  localparam int ROW_B  = ROW_W / 8;
  localparam int ROWS   = 1 << RAM_AW;
  localparam int MEM_B  = ROWS * ROW_B;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_vector;
  logic              req_stride_en;
  logic [ADDR_W-1:0] req_stride;
  logic [ADDR_W-1:0] req_addr;
  logic [LANE_W-1:0] req_sdata;
  logic [ROW_W-1:0]  req_vdata;
  logic              resp_valid;
  logic              resp_err;
  logic [LANE_W-1:0] resp_sdata;
  logic [ROW_W-1:0]  resp_vdata;
  logic              busy;
  logic [RAM_AW-1:0] ram_addr;
  logic [ROW_B-1:0]  ram_byteena;
  logic [ROW_W-1:0]  ram_wdata;
  logic              ram_wren;
  logic [ROW_W-1:0]  ram_rdata;

  logic [ROW_W-1:0]  ram_model [ROWS];
  logic [7:0]        ref_mem   [MEM_B];

  logic [ROW_B-1:0]  be_log[$];
  logic [RAM_AW-1:0] wa_log[$];

  int                err_count = 0;
  int                check_count = 0;
  logic              got_err;
  logic [LANE_W-1:0] got_s;
  logic [ROW_W-1:0]  got_v;

  vector_lsu_strided #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .RAM_AW(RAM_AW),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_vector   (req_vector),
    .req_stride_en(req_stride_en),
    .req_stride   (req_stride),
    .req_addr     (req_addr),
    .req_sdata    (req_sdata),
    .req_vdata    (req_vdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_sdata   (resp_sdata),
    .resp_vdata   (resp_vdata),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_byteena  (ram_byteena),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_rdata    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < ROW_B; b++)
        if (ram_byteena[b]) ram_model[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= ram_model[ram_addr];
  end

  // Record every write strobe so stores can be inspected afterwards.
  always @(negedge clk) begin
    if (ram_wren) begin
      be_log.push_back(ram_byteena);
      wa_log.push_back(ram_addr);
    end
  end

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] got,
                             input logic [ROW_W-1:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANE_W-1:0] model_read(input logic [ADDR_W-1:0] e);
    int idx;
    idx = int'(e % MEM_B);
    return {ref_mem[idx+1], ref_mem[idx]};
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] e, input logic [LANE_W-1:0] d);
    int idx;
    idx = int'(e % MEM_B);
    ref_mem[idx]   = d[7:0];
    ref_mem[idx+1] = d[15:8];
  endtask

  // Present one request in IDLE, wait for completion, and capture the response.
  task automatic applyStimulus(input logic w, input logic v, input logic se,
                               input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] ad,
                               input logic [LANE_W-1:0] sd, input logic [ROW_W-1:0] vd,
                               output int lat);
    be_log.delete();
    wa_log.delete();
    req_write     = w;
    req_vector    = v;
    req_stride_en = se;
    req_stride    = st;
    req_addr      = ad;
    req_sdata     = sd;
    req_vdata     = vd;
    req_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got_err = resp_err;
    got_s   = resp_sdata;
    got_v   = resp_vdata;
    @(negedge clk);
  endtask

  // Run one access through the reference model and the DUT, then compare.
  task automatic runOp(input logic w, input logic v, input logic se,
                       input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] ad,
                       input logic [LANE_W-1:0] sd, input logic [ROW_W-1:0] vd);
    int                lat;
    int                exp_lat;
    logic              fast;
    logic              err;
    logic [ADDR_W-1:0] stp;
    logic [ADDR_W-1:0] e;
    logic [LANE_W-1:0] exp_s;
    logic [ROW_W-1:0]  exp_v;
    fast    = !v || (!se && (ad % ROW_B == 0));
    exp_lat = fast ? (w ? 2 : 3) : (w ? LANES + 1 : 2 * LANES + 1);
    err     = 1'b0;
    exp_s   = '0;
    exp_v   = '0;
    if (!v) begin
      err = (ad % 2) != 0;
      if (w) begin
        if (!err) model_write(ad, sd);
      end else begin
        exp_s = err ? '0 : model_read(ad);
      end
    end else begin
      stp = se ? st : 32'd2;
      for (int i = 0; i < LANES; i++) begin
        e = ad + ADDR_W'(i) * stp;
        if (e % 2 != 0) err = 1'b1;
        if (w) begin
          if (e % 2 == 0) model_write(e, vd[i*LANE_W +: LANE_W]);
        end else begin
          exp_v[i*LANE_W +: LANE_W] = (e % 2 != 0) ? '0 : model_read(e);
        end
      end
    end
    applyStimulus(w, v, se, st, ad, sd, vd, lat);
    checkOutput("latency", ROW_W'(lat), ROW_W'(exp_lat));
    checkOutput("resp_err", ROW_W'(got_err), ROW_W'(err));
    if (w)      checkOutput("wren_cycles", ROW_W'(be_log.size()), ROW_W'(fast ? 1 : LANES));
    else if (v) checkOutput("vdata", got_v, exp_v);
    else        checkOutput("sdata", ROW_W'(got_s), ROW_W'(exp_s));
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ROW_W / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  vd;
    logic [ADDR_W-1:0] e;
    logic [ADDR_W-1:0] ad;
    logic [ADDR_W-1:0] st;
    logic [ADDR_W-1:0] stride_tab [6];
    logic [ROW_B-1:0]  exp_be;
    int                k;
    logic              saw_resp;

    for (int r = 0; r < ROWS; r++) begin
      row = rand_row();
      ram_model[r] = row;
      for (int b = 0; b < ROW_B; b++) ref_mem[r*ROW_B + b] = row[b*8 +: 8];
    end

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_vector    = 1'b0;
    req_stride_en = 1'b0;
    req_stride    = '0;
    req_addr      = '0;
    req_sdata     = '0;
    req_vdata     = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_req_ready", ROW_W'(req_ready), ROW_W'(1));
    checkOutput("rst_busy", ROW_W'(busy), ROW_W'(0));
    checkOutput("rst_resp_valid", ROW_W'(resp_valid), ROW_W'(0));
    checkOutput("rst_resp_err", ROW_W'(resp_err), ROW_W'(0));
    checkOutput("rst_ram_wren", ROW_W'(ram_wren), ROW_W'(0));
    checkOutput("rst_ram_byteena", ROW_W'(ram_byteena), ROW_W'(0));
    checkOutput("rst_ram_addr", ROW_W'(ram_addr), ROW_W'(0));
    checkOutput("rst_resp_vdata", resp_vdata, '0);
    checkOutput("rst_resp_sdata", ROW_W'(resp_sdata), ROW_W'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] scalar store and load at 0x22");
    runOp(1'b1, 1'b0, 1'b0, '0, 32'h22, 16'hBEEF, '0);
    checkOutput("scalar_be", ROW_W'(be_log.size() > 0 ? be_log[0] : '0), ROW_W'(32'h0000_000C));
    runOp(1'b0, 1'b0, 1'b0, '0, 32'h22, '0, '0);
    checkOutput("scalar_load_val", ROW_W'(got_s), ROW_W'(16'hBEEF));

    $display("[TB] fast vector store and load at 0x20");
    for (int i = 0; i < LANES; i++) vd[i*LANE_W +: LANE_W] = LANE_W'(i);
    runOp(1'b1, 1'b1, 1'b0, '0, 32'h20, '0, vd);
    checkOutput("vec_be", ROW_W'(be_log.size() > 0 ? be_log[0] : '0), ROW_W'({ROW_B{1'b1}}));
    checkOutput("vec_row", ROW_W'(wa_log.size() > 0 ? wa_log[0] : '0), ROW_W'(1));
    runOp(1'b0, 1'b1, 1'b0, '0, 32'h20, '0, '0);
    checkOutput("vec_load_val", got_v, vd);

    $display("[TB] strided load one row per element");
    runOp(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, '0, '0);

    $display("[TB] strided store with stride 3");
    vd = rand_row();
    runOp(1'b1, 1'b1, 1'b1, 32'd3, 32'h40, '0, vd);
    if (be_log.size() == LANES) begin
      for (int i = 0; i < LANES; i++) begin
        e = 32'h40 + 32'(3 * i);
        exp_be = (e % 2 != 0) ? '0 : (ROW_B'(3) << (2 * ((e % ROW_B) / 2)));
        checkOutput($sformatf("stride3_be%0d", i), ROW_W'(be_log[i]), ROW_W'(exp_be));
      end
    end

    $display("[TB] unaligned vector load at 0x12");
    runOp(1'b0, 1'b1, 1'b0, '0, 32'h12, '0, '0);

    $display("[TB] reset during scatter");
    vd = rand_row();
    req_write     = 1'b1;
    req_vector    = 1'b1;
    req_stride_en = 1'b1;
    req_stride    = 32'h20;
    req_addr      = 32'h400;
    req_vdata     = vd;
    req_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (k < 5) begin
      @(negedge clk);
      k++;
    end
    checkOutput("scatter_wren_before", ROW_W'(ram_wren), ROW_W'(1));
    reset = 1'b1;
    #1;
    checkOutput("scatter_wren_async", ROW_W'(ram_wren), ROW_W'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_write(32'h400 + 32'(i * 32), vd[i*LANE_W +: LANE_W]);
    checkOutput("post_rst_ready", ROW_W'(req_ready), ROW_W'(1));
    checkOutput("post_rst_busy", ROW_W'(busy), ROW_W'(0));
    saw_resp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) saw_resp = 1'b1;
      @(negedge clk);
    end
    checkOutput("post_rst_no_resp", ROW_W'(saw_resp), ROW_W'(0));
    runOp(1'b0, 1'b1, 1'b1, 32'h20, 32'h400, '0, '0);

    $display("[TB] random traffic");
    stride_tab[0] = 32'd0;
    stride_tab[1] = 32'd2;
    stride_tab[2] = 32'd3;
    stride_tab[3] = 32'hFFFF_FFFE;
    stride_tab[4] = 32'h20;
    stride_tab[5] = 32'hFFFF_FFDE;
    for (int n = 0; n < 40; n++) begin
      ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) ad = ad & ~32'd31;
      st = stride_tab[$urandom_range(0, 5)];
      runOp(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            st, ad, 16'($urandom), rand_row());
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
